// File: rtl/bt_air_pkg.sv
// Shared constants, delay-line entry type and LFSR helpers for the multi-node air channel.
package bt_air_pkg;

    localparam int          FK_W         = 7;
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef struct packed {
        logic            radiate;
        logic            data;
        logic [FK_W-1:0] fk;
    } air_entry_t;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
        logic [31:0] d;
        d = {x, x} << n;
        return d[31:16];
    endfunction

endpackage

// File: rtl/bt_air_delayline.sv
// DELAY-stage shift line carrying one node's radiated bit and its launch-time channel.
module bt_air_delayline
    import bt_air_pkg::*;
#(
    parameter int DELAY = 1
) (
    input  logic       clk_6M,
    input  logic       rstz,
    input  air_entry_t din,
    output air_entry_t dout
);

    air_entry_t stage_reg [DELAY];

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            for (int k = 0; k < DELAY; k++) begin
                stage_reg[k] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int k = 1; k < DELAY; k++) begin
                stage_reg[k] <= stage_reg[k-1];
            end
        end
    end

    assign dout = stage_reg[DELAY-1];

endmodule

// File: rtl/bt_air_channel.sv
// Shared-medium channel model: routes each node's delayed transmit bit to every other
// node tuned to the same channel, with noise, bit-error injection and collision flags.
module bt_air_channel
    import bt_air_pkg::*;
#(
    parameter int          NODES = 2,
    parameter int          DELAY = 1,
    parameter logic [15:0] SEED  = DEFAULT_SEED
) (
    input  logic                  clk_6M,
    input  logic                  rstz,
    input  logic [NODES-1:0]      txen,
    input  logic [NODES-1:0]      txbit,
    input  logic [FK_W*NODES-1:0] txfk,
    input  logic [NODES-1:0]      rxen,
    input  logic [FK_W*NODES-1:0] rxfk,
    input  logic [NODES-1:0]      loadfreq_p,
    input  logic [7:0]            regi_settle,
    input  logic [15:0]           regi_ber_thresh,
    output logic [NODES-1:0]      rxbit,
    output logic [NODES-1:0]      carrier,
    output logic [NODES-1:0]      collision,
    output logic [15:0]           err_cnt
);

    logic [15:0]      lfsr_reg;
    logic [15:0]      err_cnt_reg;
    logic [NODES-1:0] rxbit_reg;
    logic [NODES-1:0] carrier_reg;
    logic [NODES-1:0] collision_reg;
    logic [NODES-1:0] rxbit_next;
    logic [NODES-1:0] carrier_next;
    logic [NODES-1:0] collision_next;
    logic [NODES-1:0] err_hit;
    logic [3:0]       err_add;
    logic [16:0]      err_sum;
    air_entry_t       line_out [NODES];

    genvar gi;
    generate
        for (gi = 0; gi < NODES; gi++) begin : g_node
            localparam logic [3:0] ROT = 4'((3 * gi) % 16);

            logic [FK_W-1:0] tx_fk_reg;
            logic [FK_W-1:0] rx_fk_reg;
            logic [7:0]      settle_cnt_reg;
            logic            settled;
            logic            listen;
            logic            err_bit;
            logic            hit_bit;
            logic [3:0]      hit_cnt;
            logic            node_rx;
            logic            node_car;
            logic            node_col;
            logic            node_err;
            air_entry_t      line_in;

            always_ff @(posedge clk_6M or negedge rstz) begin
                if (!rstz) begin
                    tx_fk_reg      <= '0;
                    rx_fk_reg      <= '0;
                    settle_cnt_reg <= '0;
                end else if (loadfreq_p[gi]) begin
                    tx_fk_reg      <= txfk[FK_W*gi +: FK_W];
                    rx_fk_reg      <= rxfk[FK_W*gi +: FK_W];
                    settle_cnt_reg <= regi_settle;
                end else if (settle_cnt_reg != 8'd0) begin
                    settle_cnt_reg <= settle_cnt_reg - 8'd1;
                end
            end

            assign settled = (settle_cnt_reg == 8'd0);
            assign listen  = rxen[gi] & settled;
            // Each node looks at a different rotation so error patterns are decorrelated.
            assign err_bit = (rotl16(lfsr_reg, ROT) < regi_ber_thresh);
            assign line_in = '{radiate: txen[gi] & settled, data: txbit[gi], fk: tx_fk_reg};

            bt_air_delayline #(
                .DELAY (DELAY)
            ) u_line (
                .clk_6M (clk_6M),
                .rstz   (rstz),
                .din    (line_in),
                .dout   (line_out[gi])
            );

            always_comb begin
                hit_cnt = '0;
                hit_bit = 1'b0;
                for (int i = 0; i < NODES; i++) begin
                    if (i != gi && line_out[i].radiate && line_out[i].fk == rx_fk_reg) begin
                        hit_cnt = hit_cnt + 4'd1;
                        hit_bit = line_out[i].data;
                    end
                end
            end

            always_comb begin
                node_rx  = 1'b0;
                node_car = 1'b0;
                node_col = 1'b0;
                node_err = 1'b0;
                if (listen) begin
                    if (hit_cnt == 4'd1) begin
                        node_rx  = hit_bit ^ err_bit;
                        node_car = 1'b1;
                        node_err = err_bit;
                    end else begin
                        node_rx  = lfsr_reg[gi];
                        node_col = (hit_cnt >= 4'd2);
                    end
                end
            end

            assign rxbit_next[gi]     = node_rx;
            assign carrier_next[gi]   = node_car;
            assign collision_next[gi] = node_col;
            assign err_hit[gi]        = node_err;
        end
    endgenerate

    always_comb begin
        err_add = '0;
        for (int k = 0; k < NODES; k++) begin
            err_add = err_add + {3'd0, err_hit[k]};
        end
        err_sum = {1'b0, err_cnt_reg} + {13'd0, err_add};
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            lfsr_reg      <= SEED;
            err_cnt_reg   <= '0;
            rxbit_reg     <= '0;
            carrier_reg   <= '0;
            collision_reg <= '0;
        end else begin
            lfsr_reg      <= lfsr_step(lfsr_reg);
            err_cnt_reg   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            rxbit_reg     <= rxbit_next;
            carrier_reg   <= carrier_next;
            collision_reg <= collision_next;
        end
    end

    assign rxbit     = rxbit_reg;
    assign carrier   = carrier_reg;
    assign collision = collision_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
